pndes: RTL

//  Packet deserializer: receiving end of the 1-bit packet link driven by the packet serializer.

---
 rtl/pn_pkg.sv | 15 +
 rtl/pn_patdet.sv | 28 ++
 rtl/pndes.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/pn_pkg.sv
// rtl/pn_pkg.sv - constants and state encoding shared by the packet serializer and deserializer
package pn_pkg;

  localparam int unsigned PN_DW = 32;
  localparam int unsigned PN_LW = 5;
  localparam logic [3:0]  PN_HEADER = 4'b1101;
  localparam logic [3:0]  PN_FOOTER = 4'b0101;

  typedef enum logic [1:0] {
    HUNT = 2'b00,
    DATA = 2'b01,
    FOOT = 2'b10
  } pn_state_e;

endpackage

// File: rtl/pn_patdet.sv
// rtl/pn_patdet.sv - 4-bit serial window with combinational match against a fixed pattern
module pn_patdet #(
  parameter logic [3:0] PAT = 4'b0000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  input  logic dat_i,
  output logic hit_o
);

  logic [3:0] win_q;

  // The match includes the bit on the line now, so a hit lands on the edge that samples it.
  assign hit_o = ({win_q[2:0], dat_i} == PAT);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      win_q <= '0;
    end else if (clr_i) begin
      win_q <= '0;
    end else if (en_i) begin
      win_q <= {win_q[2:0], dat_i};
    end
  end

endmodule

// File: rtl/pndes.sv
// rtl/pndes.sv - serial packet deserializer: header hunt, MSB-first payload capture, footer check
module pndes
  import pn_pkg::*;
#(
  parameter int unsigned    DW     = PN_DW,
  parameter int unsigned    LW     = PN_LW,
  parameter logic [3:0]     HEADER = PN_HEADER,
  parameter logic [3:0]     FOOTER = PN_FOOTER
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          dat_i,
  input  logic [LW-1:0] len_i,
  output logic [DW-1:0] dat_o,
  output logic [LW-1:0] len_o,
  output logic          vld_o,
  output logic          err_o,
  output logic          busy_o
);

  localparam logic [LW-1:0] TOP = LW'(DW - 1);
  localparam logic [LW-1:0] FOOT_CNT = LW'(3);

  pn_state_e     state_q, state_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] len_q;
  logic [DW-1:0] cap_q;
  logic [DW-1:0] dat_q;
  logic [LW-1:0] len_out_q;
  logic          vld_q, err_q;
  logic          hdr_hit, ftr_hit;
  logic          start, foot_done, win_clr;
  logic [LW-1:0] idx;

  pn_patdet #(.PAT(HEADER)) u_hdr (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .clr_i (win_clr),
    .en_i  (state_q == HUNT),
    .dat_i (dat_i),
    .hit_o (hdr_hit)
  );

  // Footer window is always refilled with 4 fresh bits before the compare, so it never needs clearing.
  pn_patdet #(.PAT(FOOTER)) u_ftr (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .clr_i (1'b0),
    .en_i  (state_q == FOOT),
    .dat_i (dat_i),
    .hit_o (ftr_hit)
  );

  // Payload bit k lands at DW-1-k; k is recovered from the down-counter.
  assign idx = TOP - (len_q - cnt_q);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= HUNT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    start     = 1'b0;
    foot_done = 1'b0;
    win_clr   = 1'b0;
    case (state_q)
      HUNT: begin
        if (hdr_hit) begin
          start = 1'b1;
          if (len_i != '0) begin
            state_d = DATA;
            cnt_d   = len_i;
          end else begin
            state_d = FOOT;
            cnt_d   = FOOT_CNT;
          end
        end
      end
      DATA: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == LW'(1)) begin
          state_d = FOOT;
          cnt_d   = FOOT_CNT;
        end
      end
      FOOT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          foot_done = 1'b1;
          win_clr   = 1'b1;
          state_d   = HUNT;
          cnt_d     = '0;
        end
      end
      default: begin
        state_d = HUNT;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      len_q     <= '0;
      cap_q     <= '0;
      dat_q     <= '0;
      len_out_q <= '0;
      vld_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      vld_q <= foot_done & ftr_hit;
      err_q <= foot_done & ~ftr_hit;
      if (start) begin
        len_q <= len_i;
        cap_q <= '0;
      end
      if (state_q == DATA) begin
        cap_q[idx] <= dat_i;
      end
      if (foot_done && ftr_hit) begin
        dat_q     <= cap_q;
        len_out_q <= len_q;
      end
    end
  end

  assign dat_o  = dat_q;
  assign len_o  = len_out_q;
  assign vld_o  = vld_q;
  assign err_o  = err_q;
  assign busy_o = (state_q == DATA) || (state_q == FOOT);

endmodule
